// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin arbiter sharing one cache request port among four requesters.
// One transaction in flight at a time; the response is routed back to the requester that was granted.
module cache_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          req_valid,
   input  logic [3:0]          req_we,
   input  logic [4*ADDR_W-1:0] req_addr,
   input  logic [4*DATA_W-1:0] req_wdata,
   output logic [3:0]          req_ready,
   output logic [3:0]          resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                cache_req_valid,
   input  logic                cache_req_ready,
   output logic                cache_we,
   output logic [ADDR_W-1:0]   cache_addr,
   output logic [DATA_W-1:0]   cache_wdata,
   input  logic                cache_resp_valid,
   input  logic [DATA_W-1:0]   cache_resp_rdata,
   output logic [3:0]          grant_onehot,
   output logic [1:0]          grant_idx,
   output logic                busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [1:0]          rr_ptr_q, rr_ptr_d;
   logic [3:0]          grant_onehot_q, grant_onehot_d;
   logic                cache_req_valid_q, cache_req_valid_d;
   logic                cache_we_q, cache_we_d;
   logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
   logic [DATA_W-1:0]   cache_wdata_q, cache_wdata_d;
   logic [3:0]          resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

   logic                win_found;
   logic [1:0]          win_idx;
   logic [1:0]          cand;

   // Priority search begins at rr_ptr and wraps 3->0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      case (grant_onehot_q)
         4'b0001: grant_idx = 2'd0;
         4'b0010: grant_idx = 2'd1;
         4'b0100: grant_idx = 2'd2;
         4'b1000: grant_idx = 2'd3;
         default: grant_idx = 2'd0;
      endcase
   end

   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      grant_onehot_d    = grant_onehot_q;
      cache_req_valid_d = cache_req_valid_q;
      cache_we_d        = cache_we_q;
      cache_addr_d      = cache_addr_q;
      cache_wdata_d     = cache_wdata_q;
      resp_valid_d      = 4'b0000;
      resp_rdata_d      = resp_rdata_q;
      req_ready         = 4'b0000;
      case (state_q)
         S_IDLE: begin
            if (win_found && !rst) begin
               req_ready         = 4'b0001 << win_idx;
               cache_we_d        = req_we[win_idx];
               cache_addr_d      = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
               cache_wdata_d     = req_wdata[32'(win_idx)*DATA_W +: DATA_W];
               grant_onehot_d    = 4'b0001 << win_idx;
               cache_req_valid_d = 1'b1;
               state_d           = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cache_req_ready) begin
               cache_req_valid_d = 1'b0;
               state_d           = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cache_resp_valid) begin
               resp_rdata_d   = cache_resp_rdata;
               resp_valid_d   = grant_onehot_q;
               rr_ptr_d       = grant_idx + 2'd1;
               grant_onehot_d = 4'b0000;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= S_IDLE;
         rr_ptr_q          <= 2'd0;
         grant_onehot_q    <= 4'b0000;
         cache_req_valid_q <= 1'b0;
         cache_we_q        <= 1'b0;
         cache_addr_q      <= '0;
         cache_wdata_q     <= '0;
         resp_valid_q      <= 4'b0000;
         resp_rdata_q      <= '0;
      end else begin
         state_q           <= state_d;
         rr_ptr_q          <= rr_ptr_d;
         grant_onehot_q    <= grant_onehot_d;
         cache_req_valid_q <= cache_req_valid_d;
         cache_we_q        <= cache_we_d;
         cache_addr_q      <= cache_addr_d;
         cache_wdata_q     <= cache_wdata_d;
         resp_valid_q      <= resp_valid_d;
         resp_rdata_q      <= resp_rdata_d;
      end
   end

   assign grant_onehot    = grant_onehot_q;
   assign cache_req_valid = cache_req_valid_q;
   assign cache_we        = cache_we_q;
   assign cache_addr      = cache_addr_q;
   assign cache_wdata     = cache_wdata_q;
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = resp_rdata_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed and randomized checks of cache_port_arbiter against a round-robin model.
module tb_cache_port_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = 4'b0000;
   logic [3:0]   req_we;
   logic [127:0] req_addr;
   logic [127:0] req_wdata;
   logic [3:0]   req_ready;
   logic [3:0]   resp_valid;
   logic [31:0]  resp_rdata;
   logic         cache_req_valid;
   logic         cache_req_ready = 1'b0;
   logic         cache_we;
   logic [31:0]  cache_addr;
   logic [31:0]  cache_wdata;
   logic         cache_resp_valid = 1'b0;
   logic [31:0]  cache_resp_rdata = 32'd0;
   logic [3:0]   grant_onehot;
   logic [1:0]   grant_idx;
   logic         busy;

   logic         t_we    [4];
   logic [31:0]  t_addr  [4];
   logic [31:0]  t_wdata [4];

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_we[i]              = t_we[i];
         req_addr[i*32 +: 32]   = t_addr[i];
         req_wdata[i*32 +: 32]  = t_wdata[i];
      end
   end

   cache_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
      .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
      .cache_resp_valid(cache_resp_valid), .cache_resp_rdata(cache_resp_rdata),
      .grant_onehot(grant_onehot), .grant_idx(grant_idx), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference winner: scan requesters in priority order ptr, ptr+1, ... modulo 4.
   function automatic int model_pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {req_ready, resp_valid, cache_req_valid, cache_we, grant_onehot, grant_idx, busy}, 64'd0);
      chk({tag, "_dat"}, {cache_addr, cache_wdata | resp_rdata}, 64'd0);
   endtask

   task automatic run_txn(input logic [3:0] v, input int rdy_dly, input int resp_dly,
                          input logic [31:0] rd, output int obs_g);
      int g;
      g = model_pick(v, m_ptr);
      obs_g = -1;
      req_valid = v;
      #1;
      chk("req_ready_t0", req_ready, (g < 0) ? 4'b0000 : (4'b0001 << g));
      if (g >= 0) begin
         tick();
         req_valid = v & ~(4'b0001 << g);
         #1;
         obs_g = int'(grant_idx);
         chk("issue_valid", cache_req_valid, 1'b1);
         chk("issue_fields", {31'd0, cache_we, cache_addr}, {31'd0, t_we[g], t_addr[g]});
         chk("issue_wdata", cache_wdata, t_wdata[g]);
         chk("issue_grant", grant_onehot, 4'b0001 << g);
         chk("issue_busy_ready", {busy, req_ready}, {1'b1, 4'b0000});
         for (int c = 0; c < rdy_dly; c++) begin
            cache_resp_valid = 1'($urandom % 2);
            tick();
            chk("bp_hold", {27'd0, cache_req_valid, cache_we, cache_addr}, {27'd0, 1'b1, t_we[g], t_addr[g]});
            chk("bp_wdata", cache_wdata, t_wdata[g]);
            chk("bp_busy_ready", {busy, req_ready}, {1'b1, 4'b0000});
         end
         cache_req_ready  = 1'b1;
         cache_resp_valid = 1'($urandom % 2);
         tick();
         cache_req_ready  = 1'b0;
         cache_resp_valid = 1'b0;
         chk("wait_state", {cache_req_valid, busy, resp_valid, req_ready}, {1'b0, 1'b1, 4'b0000, 4'b0000});
         for (int c = 0; c < resp_dly; c++) begin
            tick();
            chk("wait_hold", {busy, resp_valid, req_ready}, {1'b1, 4'b0000, 4'b0000});
         end
         cache_resp_valid = 1'b1;
         cache_resp_rdata = rd;
         tick();
         cache_resp_valid = 1'b0;
         chk("resp_valid", resp_valid, 4'b0001 << g);
         chk("resp_rdata", resp_rdata, rd);
         chk("resp_idle", {busy, grant_onehot}, 5'd0);
         m_ptr = (g + 1) % 4;
      end
      req_valid = 4'b0000;
   endtask

   initial begin
      int g;
      int exp_order [6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 4; i++) begin
         t_we[i] = 1'b0; t_addr[i] = 32'h1000 * (i + 1); t_wdata[i] = 32'hA0 + i;
      end

      // Reset with every requester asking
      rst = 1'b1; req_valid = 4'b1111;
      tick(); chk_zero("reset_c1");
      tick(); chk_zero("reset_c2");
      rst = 1'b0; req_valid = 4'b0000;
      tick(); chk_zero("reset_after");

      // Single read from requester 1
      t_addr[1] = 32'h100; t_we[1] = 1'b0;
      run_txn(4'b0010, 0, 1, 32'hDEADBEEF, g);
      chk("single_grant_idx", 64'(g), 64'd1);

      // Fairness from a fresh pointer
      rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
      for (int n = 0; n < 6; n++) begin
         run_txn(4'b1111, 0, 0, $urandom, g);
         chk("fair_order", 64'(g), 64'(exp_order[n]));
      end

      // Rotation: after serving 2, requester 3 beats 0
      run_txn(4'b0100, 0, 0, $urandom, g);
      chk("rot_first", 64'(g), 64'd2);
      run_txn(4'b1001, 0, 0, $urandom, g);
      chk("rot_second", 64'(g), 64'd3);

      // Backpressure on a write while others stay valid
      t_we[0] = 1'b1; t_addr[0] = 32'hC0; t_wdata[0] = 32'h55;
      run_txn(4'b1111, 5, 0, $urandom, g);
      chk("bp_grant", 64'(g), 64'd0);

      // Abort in WAIT after moving the pointer to 2
      run_txn(4'b0010, 0, 0, $urandom, g);
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0000; cache_req_ready = 1'b1;
      tick();
      cache_req_ready = 1'b0;
      chk("abort_in_wait", busy, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_zero("abort_rst");
      cache_resp_valid = 1'b1; cache_resp_rdata = 32'h12345678;
      tick();
      cache_resp_valid = 1'b0;
      chk_zero("abort_no_resp");
      m_ptr = 0;
      run_txn(4'b1010, 0, 0, $urandom, g);
      chk("abort_ptr_zero", 64'(g), 64'd1);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            t_we[i] = 1'($urandom % 2); t_addr[i] = $urandom; t_wdata[i] = $urandom;
         end
         run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
